// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared constants and the reset-divisor helper for the
//                fractional baud tick generator.
//                Provides the default SAMPLING, FRAC_W and DIV_W, the minimum
//                legal integer divisor DIV_MIN, and calc_div(), which returns
//                the fixed-point divisor
//                round(f_clock * 2^frac_w / (baudrate * sampling)).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int SAMPLING = 16;
  localparam int FRAC_W   = 4;
  localparam int DIV_W    = 16;
  localparam int DIV_MIN  = 2;

  // Fixed-point divisor with FRAC_W fraction bits, rounded to nearest.
  function automatic longint calc_div(input real f_clock,
                                      input real baudrate,
                                      input int  sampling,
                                      input int  frac_w);
    real scaled;
    scaled = f_clock * real'(longint'(1) << frac_w) / (baudrate * real'(sampling));
    return longint'($rtoi(scaled + 0.5));
  endfunction

endpackage
`default_nettype wire

// File: rtl/frac_tick_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : frac_tick_divider
//  Description : Fractional-N down-counter. The counter reloads with
//                int-1 (+1 when the fraction accumulator carries), so tick
//                spacing is int or int+1 clocks and averages int + frac/2^W.
//  Ports       : i_clk, i_reset_n  - clock, async active-low reset
//                i_enable          - run; low holds cnt/acc
//                i_sync            - reload cnt, clear acc, suppress tick
//                i_apply           - a new divisor is taking effect: clear acc
//                i_reload_int      - integer divisor used for the reload
//                i_frac            - active fractional divisor
//                o_due             - enabled cycle with cnt == 0
//                o_tick            - raw tick (o_due and not i_sync)
//  Revision    : 1.0 - initial release
// ============================================================================
module frac_tick_divider #(
  parameter int               DIV_W   = 16,
  parameter int               FRAC_W  = 4,
  parameter logic [DIV_W-1:0] RST_CNT = '0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic              i_sync,
  input  logic              i_apply,
  input  logic [DIV_W-1:0]  i_reload_int,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_due,
  output logic              o_tick
);

  logic [DIV_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W:0]   w_sum;
  logic              w_carry;
  logic [DIV_W-1:0]  w_reload;

  assign w_sum    = {1'b0, r_acc} + {1'b0, i_frac};
  assign w_carry  = w_sum[FRAC_W];
  assign w_reload = i_reload_int - DIV_W'(1);
  assign o_due    = i_enable && (r_cnt == '0);
  assign o_tick   = o_due && !i_sync;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= RST_CNT;
      r_acc <= '0;
    end else if (i_sync) begin
      r_cnt <= w_reload;
      r_acc <= '0;
    end else if (i_enable) begin
      if (r_cnt == '0) begin
        if (i_apply) begin
          // New divisor: first period is exactly its integer part.
          r_cnt <= w_reload;
          r_acc <= '0;
        end else begin
          // Cannot overflow: w_reload <= 2^DIV_W-2 for any legal divisor.
          r_cnt <= w_reload + DIV_W'(w_carry);
          r_acc <= w_sum[FRAC_W-1:0];
        end
      end else begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end else if (i_apply) begin
      // Divisor swapped while frozen: keep the count, restart the fraction.
      r_acc <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/baudrate_generator_frac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : baudrate_generator_frac
//  Description : Programmable fractional-N baud tick generator with
//                oversampling tick, bit tick, enable, phase restart and
//                run-time divisor load (integer + fraction).
//  Ports       : i_clk, i_reset_n       - clock, async active-low reset
//                i_enable               - run; low freezes all counters
//                i_sync                 - restart tick phase (no tick)
//                i_div_load             - capture i_div_int / i_div_frac
//                i_div_int, i_div_frac  - divisor, int >= 2, frac in 2^-FRAC_W
//                o_tick                 - oversampling tick pulse
//                o_bit_tick             - pulse with every SAMPLING-th tick
//                o_sample_idx           - index of latest tick within the bit
//                o_div_err              - pulse: load rejected (int < 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module baudrate_generator_frac #(
  parameter real F_CLOCK  = 50E6,
  parameter real BAUDRATE = 9600,
  parameter int  SAMPLING = uart_pkg::SAMPLING,
  parameter int  DIV_W    = uart_pkg::DIV_W,
  parameter int  FRAC_W   = uart_pkg::FRAC_W
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_enable,
  input  logic                        i_sync,
  input  logic                        i_div_load,
  input  logic [DIV_W-1:0]            i_div_int,
  input  logic [FRAC_W-1:0]           i_div_frac,
  output logic                        o_tick,
  output logic                        o_bit_tick,
  output logic [$clog2(SAMPLING)-1:0] o_sample_idx,
  output logic                        o_div_err
);

  import uart_pkg::calc_div;
  import uart_pkg::DIV_MIN;

  localparam int                    c_idx_w    = $clog2(SAMPLING);
  localparam longint                c_d0       = calc_div(F_CLOCK, BAUDRATE, SAMPLING, FRAC_W);
  localparam logic [DIV_W-1:0]      c_def_int  = DIV_W'(c_d0 >> FRAC_W);
  localparam logic [FRAC_W-1:0]     c_def_frac = FRAC_W'(c_d0);
  localparam logic [DIV_W-1:0]      c_rst_cnt  = c_def_int - DIV_W'(1);
  localparam logic [c_idx_w-1:0]    c_last_idx = c_idx_w'(SAMPLING - 1);

  logic [DIV_W-1:0]   r_act_int;
  logic [FRAC_W-1:0]  r_act_frac;
  logic [DIV_W-1:0]   r_pend_int;
  logic [FRAC_W-1:0]  r_pend_frac;
  logic               r_pend_vld;
  logic [c_idx_w-1:0] r_s;
  logic               r_tick;
  logic               r_bit_tick;
  logic [c_idx_w-1:0] r_idx;
  logic               r_div_err;

  logic               w_load_ok;
  logic               w_load_bad;
  logic               w_due;
  logic               w_tick;
  logic               w_apply;
  logic [DIV_W-1:0]   w_reload_int;

  assign w_load_bad = i_div_load && (i_div_int < DIV_W'(DIV_MIN));
  assign w_load_ok  = i_div_load && !w_load_bad;

  // A pending divisor takes effect at a tick boundary, on sync, or while
  // frozen; the reload value switches in the same cycle it is applied.
  assign w_apply      = r_pend_vld && (i_sync || !i_enable || w_due);
  assign w_reload_int = w_apply ? r_pend_int : r_act_int;

  frac_tick_divider #(
    .DIV_W   (DIV_W),
    .FRAC_W  (FRAC_W),
    .RST_CNT (c_rst_cnt)
  ) u_div (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_enable     (i_enable),
    .i_sync       (i_sync),
    .i_apply      (w_apply),
    .i_reload_int (w_reload_int),
    .i_frac       (r_act_frac),
    .o_due        (w_due),
    .o_tick       (w_tick)
  );

  // Divisor registers. A load in the same cycle as an apply stays pending
  // (it was not visible yet), so the newest load always wins.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_act_int   <= c_def_int;
      r_act_frac  <= c_def_frac;
      r_pend_int  <= c_def_int;
      r_pend_frac <= c_def_frac;
      r_pend_vld  <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_int  <= r_pend_int;
        r_act_frac <= r_pend_frac;
      end
      if (w_load_ok) begin
        r_pend_int  <= i_div_int;
        r_pend_frac <= i_div_frac;
        r_pend_vld  <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Sample counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s        <= '0;
      r_tick     <= 1'b0;
      r_bit_tick <= 1'b0;
      r_idx      <= '0;
      r_div_err  <= 1'b0;
    end else begin
      r_tick     <= w_tick;
      r_bit_tick <= w_tick && (r_s == c_last_idx);
      r_div_err  <= w_load_bad;
      if (i_sync) begin
        r_s <= '0;
      end else if (w_tick) begin
        r_idx <= r_s;
        r_s   <= (r_s == c_last_idx) ? '0 : r_s + c_idx_w'(1);
      end
    end
  end

  assign o_tick       = r_tick;
  assign o_bit_tick   = r_bit_tick;
  assign o_sample_idx = r_idx;
  assign o_div_err    = r_div_err;

endmodule
`default_nettype wire

// File: tb/tb_baudrate_generator_frac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_baudrate_generator_frac
//  Description : Directed self-checking bench for baudrate_generator_frac
//                with default parameters (divisor 325 + 8/16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_baudrate_generator_frac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sync;
  logic        load;
  logic [15:0] dint;
  logic [3:0]  dfrac;
  logic        o_tick;
  logic        o_bit_tick;
  logic [3:0]  o_sample_idx;
  logic        o_div_err;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  baudrate_generator_frac dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_enable     (en),
    .i_sync       (sync),
    .i_div_load   (load),
    .i_div_int    (dint),
    .i_div_frac   (dfrac),
    .o_tick       (o_tick),
    .o_bit_tick   (o_bit_tick),
    .o_sample_idx (o_sample_idx),
    .o_div_err    (o_div_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Waits (bounded) for the next o_tick, sampled on the falling edge.
  task automatic wait_tick(output int t, output logic [3:0] idx, output logic bt);
    logic found;
    found = 1'b0;
    t     = -1;
    idx   = '0;
    bt    = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (o_tick) begin
        found = 1'b1;
        t     = cyc;
        idx   = o_sample_idx;
        bt    = o_bit_tick;
      end
    end
    if (!found) check_eq("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] vi, input logic [3:0] vf, output logic err);
    load  = 1'b1;
    dint  = vi;
    dfrac = vf;
    @(negedge clk);
    err  = o_div_err;
    load = 1'b0;
  endtask

  initial begin
    int         t, prev, first, r0, sc, ta, b1;
    logic [3:0] idx;
    logic       bt, err;

    rst_n = 1'b0; en = 1'b0; sync = 1'b0; load = 1'b0; dint = '0; dfrac = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_tick", o_tick, 0);
    check_eq("rst_bit",  o_bit_tick, 0);
    check_eq("rst_idx",  o_sample_idx, 0);
    check_eq("rst_err",  o_div_err, 0);

    // Default divisor 325 + 8/16: periods 325,326,... and bit tick on #16.
    rst_n = 1'b1; en = 1'b1; r0 = cyc;
    wait_tick(t, idx, bt);
    check_eq("first_lat", t - r0, 325);
    check_eq("first_idx", idx, 0);
    prev = t; first = t;
    for (int k = 2; k <= 17; k++) begin
      wait_tick(t, idx, bt);
      check_eq("def_period", t - prev, (k % 2 == 0) ? 325 : 326);
      check_eq("def_idx", idx, (k - 1) % 16);
      check_eq("def_bit", bt, (k == 16) ? 1 : 0);
      prev = t;
    end
    check_eq("def_span16", t - first, 5208);

    // Fresh reset, then load 4/0 mid-period: old period completes, then 4s.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; r0 = cyc;
    wait_tick(t, idx, bt);
    check_eq("rst2_lat", t - r0, 325);
    prev = t;
    do_load(16'd4, 4'd0, err);
    check_eq("load_ok_err", err, 0);
    wait_tick(t, idx, bt);
    check_eq("old_period", t - prev, 325);
    prev = t;
    for (int k = 0; k < 4; k++) begin
      wait_tick(t, idx, bt);
      check_eq("int4_period", t - prev, 4);
      prev = t;
    end

    // Illegal loads: error pulse for one cycle, spacing unchanged.
    do_load(16'd1, 4'd3, err);
    check_eq("err_int1", err, 1);
    @(negedge clk);
    check_eq("err_int1_clr", o_div_err, 0);
    do_load(16'd0, 4'd0, err);
    check_eq("err_int0", err, 1);
    @(negedge clk);
    check_eq("err_int0_clr", o_div_err, 0);
    wait_tick(prev, idx, bt);
    for (int k = 0; k < 3; k++) begin
      wait_tick(t, idx, bt);
      check_eq("bad_load_period", t - prev, 4);
      prev = t;
    end

    // 4 + 8/16: first period 4, then 4,5,4,5; 200 periods = 900 cycles.
    wait_tick(prev, idx, bt);
    do_load(16'd4, 4'd8, err);
    wait_tick(ta, idx, bt);
    check_eq("frac_apply", ta - prev, 4);
    wait_tick(b1, idx, bt);
    check_eq("frac_first", b1 - ta, 4);
    prev = b1;
    for (int k = 1; k <= 200; k++) begin
      wait_tick(t, idx, bt);
      if (k <= 4) check_eq("frac_period", t - prev, (k % 2 == 1) ? 4 : 5);
      prev = t;
    end
    check_eq("frac_span200", t - b1, 900);

    // Sync two cycles after a tick: next tick 4 after sync, index 0.
    wait_tick(t, idx, bt);
    repeat (2) @(negedge clk);
    sync = 1'b1; @(negedge clk); sc = cyc; sync = 1'b0;
    wait_tick(t, idx, bt);
    check_eq("sync_lat", t - sc, 4);
    check_eq("sync_idx", idx, 0);

    // Sync on the cycle a tick is due: that tick is suppressed.
    repeat (3) @(negedge clk);
    sync = 1'b1; @(negedge clk);
    check_eq("sync_supp", o_tick, 0);
    sc = cyc; sync = 1'b0;
    wait_tick(t, idx, bt);
    check_eq("sync_due_lat", t - sc, 4);
    check_eq("sync_due_idx", idx, 0);

    // Pending divisor is applied by the sync reload.
    do_load(16'd6, 4'd0, err);
    sync = 1'b1; @(negedge clk); sc = cyc; sync = 1'b0;
    wait_tick(t, idx, bt);
    check_eq("sync_apply_lat", t - sc, 6);

    // Enable low for 7 cycles mid-period delays the tick by exactly 7.
    prev = t;
    @(negedge clk); en = 1'b0;
    repeat (7) @(negedge clk);
    en = 1'b1;
    wait_tick(t, idx, bt);
    check_eq("en_delay", t - prev, 13);
    prev = t;
    wait_tick(t, idx, bt);
    check_eq("en_after", t - prev, 6);
    check_eq("en_idx", idx, 2);

    // Asynchronous reset while o_tick is high.
    #2 rst_n = 1'b0;
    #1;
    check_eq("areset_tick", o_tick, 0);
    check_eq("areset_idx", o_sample_idx, 0);
    @(negedge clk); rst_n = 1'b1; r0 = cyc;
    wait_tick(t, idx, bt);
    check_eq("areset_lat", t - r0, 325);
    prev = t;
    wait_tick(t, idx, bt);
    check_eq("areset_period", t - prev, 325);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/baudrate_generator_frac.md
Name: baudrate_generator_frac

Overview:
Programmable fractional-N baud tick generator. It is the successor to the fixed-divisor generator and sits between the clock and the uart rx/tx blocks. Features: run-time divisor load (integer plus fraction), an oversampling tick, a bit tick, an enable, and a synchronous phase restart so the rx block can realign on a start-bit edge. The average tick period is DIV_INT + DIV_FRAC/2^FRAC_W clocks.

Parameters:
F_CLOCK, 50E6, input clock frequency in Hz
BAUDRATE, 9600, baud rate used to compute the reset divisor
SAMPLING, 16, oversampling ticks per bit (>=2)
DIV_W, 16, integer divisor width
FRAC_W, 4, fractional divisor width

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous reset, active-low
i_enable  in  1  run; low freezes all counters
i_sync  in  1  one-cycle pulse; restarts tick phase
i_div_load  in  1  one-cycle pulse; captures i_div_int/i_div_frac
i_div_int  in  DIV_W  integer divisor (clocks per tick), legal >=2
i_div_frac  in  FRAC_W  fractional divisor, units of 2^-FRAC_W
o_tick  out  1  oversampling tick, one-cycle pulse
o_bit_tick  out  1  one-cycle pulse coincident with every SAMPLING-th o_tick
o_sample_idx  out  clog2(SAMPLING)  index of the most recent tick within the bit, 0..SAMPLING-1
o_div_err  out  1  one-cycle pulse: load rejected

Behaviour:
- Reset divisor D0 = round(F_CLOCK*2^FRAC_W/(BAUDRATE*SAMPLING)). DEF_INT = D0>>FRAC_W; DEF_FRAC = D0 mod 2^FRAC_W. Defaults give 325 and 8.
- Asynchronous reset:
  - active = pending = default divisor; no pending flag.
  - Down-counter cnt = DEF_INT-1; fraction accumulator acc = 0; sample counter s = 0.
  - All outputs 0.
- Priority per cycle: reset > i_sync > i_enable.
- Enabled cycle, cnt != 0: cnt decrements.
- Enabled cycle, cnt == 0 (tick boundary):
  - {carry, acc} <= acc + active_frac, computed FRAC_W+1 wide.
  - cnt <= active_int - 1 + carry.
  - o_tick is registered high in the next cycle.
  - s increments, wrapping SAMPLING-1 -> 0.
  - o_sample_idx <= old s.
  - o_bit_tick is registered high with that o_tick when old s == SAMPLING-1.
- Tick spacing: exactly active_int or active_int+1 clocks. The first period after reset, sync or a divisor change is active_int, because acc = 0.
- i_enable low:
  - cnt, acc and s hold.
  - o_tick and o_bit_tick are 0 from the next cycle.
  - Resuming continues the same phase; no extra or lost tick.
- i_sync (regardless of i_enable):
  - cnt <= active_int-1; acc <= 0; s <= 0.
  - No tick is generated; a tick due in that same cycle is suppressed.
  - A pending divisor is applied before the reload, so cnt <= pending_int-1.
- i_div_load:
  - If i_div_int < 2: o_div_err is high the next cycle and nothing changes.
  - Otherwise the value is stored as pending and the pending flag is set.
  - Pending is copied to active at the next tick boundary, sync, or any cycle with i_enable low. It then sets the reload value and acc resets to 0.
  - A load coincident with a tick boundary applies at the following boundary, not the current one.
  - A second load before application overwrites pending. Last load wins.
- Divisor width: i_div_int max 2^DIV_W-1. cnt is DIV_W bits. active_int-1+carry never overflows because carry only adds 1 to active_int-1 <= 2^DIV_W-2.
- Frac = 0 reproduces the fixed-divisor generator exactly.

Decomposition:
- uart_pkg holds:
  - constants SAMPLING, FRAC_W, DIV_W;
  - function calc_div(F_CLOCK, BAUDRATE, SAMPLING, FRAC_W) returning D0;
  - localparam DIV_MIN = 2.
- One sub-module, frac_tick_divider, holds cnt, acc, the carry reload and the raw tick.
- baudrate_generator_frac wraps it and owns pending/active registers, load validation, the sample counter and output registers.

Test Plan:
- Default parameters, enable high after reset -> o_tick periods alternate per 16-tick window. Fraction 8/16 gives a 325,326 alternation starting with 325. o_bit_tick once every 16 ticks with o_sample_idx=15.
- Load int=4 frac=0 while enabled -> the current period completes at the old divisor, then ticks exactly every 4 cycles.
- Load int=4 frac=8 (FRAC_W=4) -> periods 4,5,4,5; 200 ticks span exactly 900 cycles.
- Load int=1 -> o_div_err one-cycle pulse, tick spacing unchanged. Load int=0 gives the same result.
- With int=4, assert i_sync two cycles after a tick -> next tick exactly 4 cycles after the sync, o_sample_idx=0 on it. A sync on a due-tick cycle produces no tick.
- Drop i_enable for 7 cycles mid-period, then deassert i_reset_n mid-period -> while low, the tick is delayed by exactly 7 cycles. On reset, all outputs go 0 immediately (asynchronous) and the default divisor is restored.
